prio_grant_arb: RTL and testbench
=================================

# prio_grant_arb

Parametrised, registered successor to the team's 8-input combinational priority encoder. Arbitrates N request lines and issues one held, one-hot grant plus its binary index. The grant persists until the holder signals completion. Selectable fixed-priority mode (lowest index wins, matching the existing encoder) or round-robin mode. Sits between multiple requesters (DMA channels, bus masters) and a single shared resource.

## Interface
- `N`, default 8: number of request lines; legal range 2..64.
- `RR`, default 0: arbitration mode. 0 = fixed priority, bit 0 highest. 1 = round-robin.
- `W`, localparam = $clog2(N): width of the grant index. Not overridable.

Ports (name, direction, width, meaning):
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N: request vector; bit i = requester i wants the resource.
- `done`  in  1: current grant holder releases the resource; only meaningful while `gnt_valid`=1.
- `gnt`  out  N: registered one-hot grant; all zero when no grant is held.
- `gnt_code`  out  W: registered binary index of the granted line; 0 when no grant is held. Never X.
- `gnt_valid`  out  1: registered; 1 while a grant is held.

## Operation
- State machine, two states:
  - IDLE: no grant held.
  - BUSY: grant held.
- Reset (`rst`=1 at an edge):
  - State ← IDLE.
  - `gnt`=0, `gnt_code`=0, `gnt_valid`=0.
  - Round-robin pointer `ptr` ← 0.
  - `rst` has priority over every other input.
- IDLE, `req`=0: stay in IDLE; outputs remain 0.
- IDLE, `req`≠0:
  - Select winner w.
  - Next edge: `gnt`=1<<w, `gnt_code`=w, `gnt_valid`=1, state ← BUSY.
- Winner selection, RR=0: lowest set index of `req`.
- Winner selection, RR=1:
  - Search begins at `ptr`, ascending with wrap.
  - w = first set bit at index ≥ `ptr`; if none, the lowest set bit below `ptr`.
- BUSY, `done`=0:
  - Grant outputs frozen.
  - Changes on `req`, including the holder deasserting its own request, are ignored.
- BUSY, `done`=1:
  - Next edge: `gnt`=0, `gnt_code`=0, `gnt_valid`=0, state ← IDLE.
  - If RR=1: `ptr` ← (w+1) mod N, wrapping N-1 → 0.
  - If RR=0: `ptr` is unused and stays 0.
- `done` in IDLE is ignored.
- At most one grant bit is ever set; `gnt` and `gnt_code` always agree.
- No combinational path from `req` or `done` to any output.

## Timing
- Request-to-grant latency: 1 cycle. `req` sampled at IDLE edge k; grant visible after edge k.
- Release latency: 1 cycle. `done` sampled at edge k; outputs clear after edge k.
- Re-arbitration gap: minimum one IDLE cycle between consecutive grants.
  - Next grant is sampled at edge k+1 and visible after edge k+1.
  - Grant period is therefore ≥ 2 cycles per transaction.
- Simultaneous requests: resolved entirely within a single IDLE cycle; no partial or multiple grants.
- Reset mid-BUSY: grant dropped at that edge and `ptr` cleared. The holder receives no `done`-style acknowledge.
- `done` and `rst` at the same edge: reset wins; result is identical to reset alone.
- `req` changing at the grant edge: the value sampled at that edge decides the winner.

## Test plan
- Reset, fixed mode (N=8, RR=0): assert `rst` with `req`=8'hFF for 2 cycles -> `gnt`=0, `gnt_code`=0, `gnt_valid`=0 throughout. First IDLE edge after reset -> `gnt`=8'h01, `gnt_code`=0.
- Fixed priority (RR=0): `req`=8'b1010_0100 -> `gnt`=8'h04, `gnt_code`=2 one cycle later. Change `req` to 8'h01 with `done`=0 for 5 cycles -> grant stays 8'h04. Pulse `done` -> outputs 0 next cycle, then `gnt`=8'h01 one cycle after that.
- Round-robin fairness (RR=1): hold `req`=8'hFF and pulse `done` every grant -> `gnt_code` sequence 0,1,2,…,7,0. Wrap from 7 → 0 verified; exactly one idle cycle between grants.
- Round-robin skip (RR=1): `ptr`=3 after granting 2; `req`=8'b0000_0011 -> `gnt_code`=0 via wrap search. After release, `ptr`=1.
- Boundaries:
  - `done` pulsed in IDLE with `req`=0 -> no output change.
  - `rst` and `done` asserted together in BUSY -> outputs 0 and next RR grant starts from index 0.
- Parameter sweep: N=2, N=5 (non-power-of-2, W=3) and N=64, both modes.
  - Check every cycle: one-hot `gnt`; `gnt_code` equals the grant index; `gnt_code` < N.

Source files
------------

// File: rtl/prio_grant_arb.sv
// Registered N-way arbiter: one held one-hot grant plus its index,
// fixed-priority (bit 0 highest) or round-robin, released by done.
module prio_grant_arb #(
  parameter  int N  = 8,
  parameter  int RR = 0,
  localparam int W  = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_code,
  output logic         gnt_valid
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_gnt;
  logic [N-1:0] w_gnt_nxt;
  logic [W-1:0] r_code;
  logic [W-1:0] w_code_nxt;
  logic         r_valid;
  logic         w_valid_nxt;
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr_nxt;

  logic [N-1:0] w_hi_mask;
  logic [N-1:0] w_req_hi;
  logic [W-1:0] w_lo_idx;
  logic [W-1:0] w_hi_idx;
  logic [W-1:0] w_win;
  logic [N-1:0] w_win_oh;
  logic [W-1:0] w_ptr_inc;

  // Requests at or above the pointer get first pick; else wrap to the lowest.
  always_comb begin
    w_hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_hi_mask[i] = (W'(i) >= r_ptr);
    end
  end

  assign w_req_hi = req & w_hi_mask;

  always_comb begin
    w_lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_idx = W'(i);
      end
    end
  end

  always_comb begin
    w_hi_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req_hi[i]) begin
        w_hi_idx = W'(i);
      end
    end
  end

  assign w_win = ((RR != 0) && (|w_req_hi))
               ? w_hi_idx
               : w_lo_idx;

  assign w_win_oh = {{(N-1){1'b0}}, 1'b1} << w_win;

  assign w_ptr_inc = (r_code == W'(N - 1))
                   ? '0
                   : r_code + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_code_nxt  = r_code;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt = S_BUSY;
          w_gnt_nxt   = w_win_oh;
          w_code_nxt  = w_win;
          w_valid_nxt = 1'b1;
        end
      end
      S_BUSY: begin
        if (done) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_code_nxt  = '0;
          w_valid_nxt = 1'b0;
          if (RR != 0) begin
            w_ptr_nxt = w_ptr_inc;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_code  <= w_code_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_code  = r_code;
  assign gnt_valid = r_valid;

endmodule

// File: tb/tb_prio_grant_arb.sv
// Bench for prio_grant_arb: directed N=8 scoreboards for both modes,
// plus a randomised sweep of N=2/5/64 against a rotating-search model.
module tb_prio_grant_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic       v;
    logic [7:0] g;
    logic [2:0] c;
  } exp_t;

  exp_t q_fx[$];
  exp_t q_rr[$];

  logic       fx_rst, fx_done, fx_valid;
  logic [7:0] fx_req, fx_gnt;
  logic [2:0] fx_code;
  logic       rr_rst, rr_done, rr_valid;
  logic [7:0] rr_req, rr_gnt;
  logic [2:0] rr_code;

  prio_grant_arb #(.N(8), .RR(0)) u_fx (
    .clk(clk), .rst(fx_rst), .req(fx_req), .done(fx_done),
    .gnt(fx_gnt), .gnt_code(fx_code), .gnt_valid(fx_valid)
  );

  prio_grant_arb #(.N(8), .RR(1)) u_rr (
    .clk(clk), .rst(rr_rst), .req(rr_req), .done(rr_done),
    .gnt(rr_gnt), .gnt_code(rr_code), .gnt_valid(rr_valid)
  );

  task automatic cf(input logic rs, input logic [7:0] rq,
                    input logic dn, input logic ev,
                    input logic [7:0] eg, input logic [2:0] ec);
    exp_t e;
    @(negedge clk);
    #1;
    fx_rst = rs; fx_req = rq; fx_done = dn;
    e = {ev, eg, ec};
    q_fx.push_back(e);
  endtask

  task automatic cr(input logic rs, input logic [7:0] rq,
                    input logic dn, input logic ev,
                    input logic [7:0] eg, input logic [2:0] ec);
    exp_t e;
    @(negedge clk);
    #1;
    rr_rst = rs; rr_req = rq; rr_done = dn;
    e = {ev, eg, ec};
    q_rr.push_back(e);
  endtask

  always @(negedge clk) begin : mon_fx
    exp_t e;
    if (q_fx.size() > 0) begin
      e = q_fx.pop_front();
      chk("fixed", 80'({fx_valid, fx_gnt, fx_code}), 80'(e));
    end
  end

  always @(negedge clk) begin : mon_rr
    exp_t e;
    if (q_rr.size() > 0) begin
      e = q_rr.pop_front();
      chk("rrobin", 80'({rr_valid, rr_gnt, rr_code}), 80'(e));
    end
  end

  // Parameter sweep
  localparam int SN [6] = '{2, 2, 5, 5, 64, 64};
  localparam int SR [6] = '{0, 1, 0, 1, 0, 1};

  logic        s_rst, s_done, s_chk, sw_done;
  logic [63:0] s_req;
  logic [1:0]  g20, g21;
  logic [4:0]  g50, g51;
  logic [63:0] g640, g641;
  logic        c20, c21;
  logic [2:0]  c50, c51;
  logic [5:0]  c640, c641;
  logic        v20, v21, v50, v51, v640, v641;

  prio_grant_arb #(.N(2), .RR(0)) u_s20 (
    .clk(clk), .rst(s_rst), .req(s_req[1:0]), .done(s_done),
    .gnt(g20), .gnt_code(c20), .gnt_valid(v20));
  prio_grant_arb #(.N(2), .RR(1)) u_s21 (
    .clk(clk), .rst(s_rst), .req(s_req[1:0]), .done(s_done),
    .gnt(g21), .gnt_code(c21), .gnt_valid(v21));
  prio_grant_arb #(.N(5), .RR(0)) u_s50 (
    .clk(clk), .rst(s_rst), .req(s_req[4:0]), .done(s_done),
    .gnt(g50), .gnt_code(c50), .gnt_valid(v50));
  prio_grant_arb #(.N(5), .RR(1)) u_s51 (
    .clk(clk), .rst(s_rst), .req(s_req[4:0]), .done(s_done),
    .gnt(g51), .gnt_code(c51), .gnt_valid(v51));
  prio_grant_arb #(.N(64), .RR(0)) u_s640 (
    .clk(clk), .rst(s_rst), .req(s_req), .done(s_done),
    .gnt(g640), .gnt_code(c640), .gnt_valid(v640));
  prio_grant_arb #(.N(64), .RR(1)) u_s641 (
    .clk(clk), .rst(s_rst), .req(s_req), .done(s_done),
    .gnt(g641), .gnt_code(c641), .gnt_valid(v641));

  logic [63:0] sg [6];
  logic [5:0]  sc [6];
  logic        sv [6];

  always_comb begin
    sg[0] = 64'(g20);  sc[0] = 6'(c20);  sv[0] = v20;
    sg[1] = 64'(g21);  sc[1] = 6'(c21);  sv[1] = v21;
    sg[2] = 64'(g50);  sc[2] = 6'(c50);  sv[2] = v50;
    sg[3] = 64'(g51);  sc[3] = 6'(c51);  sv[3] = v51;
    sg[4] = g640;      sc[4] = c640;     sv[4] = v640;
    sg[5] = g641;      sc[5] = c641;     sv[5] = v641;
  end

  function automatic logic [6:0] pick(input logic [63:0] rq,
                                      input int n, input int rr,
                                      input int p);
    for (int o = 0; o < n; o++) begin
      int j;
      j = (rr != 0) ? (p + o) % n : o;
      if (rq[j]) return {1'b1, 6'(j)};
    end
    return 7'd0;
  endfunction

  logic       m_v [6];
  logic [5:0] m_c [6];
  logic [5:0] m_p [6];

  always @(posedge clk) begin : model
    logic [6:0] pk;
    for (int k = 0; k < 6; k++) begin
      if (s_rst) begin
        m_v[k] <= 1'b0; m_c[k] <= '0; m_p[k] <= '0;
      end else if (!m_v[k]) begin
        pk = pick(s_req, SN[k], SR[k], int'(m_p[k]));
        if (pk[6]) begin
          m_v[k] <= 1'b1; m_c[k] <= pk[5:0];
        end
      end else if (s_done) begin
        m_v[k] <= 1'b0; m_c[k] <= '0;
        if (SR[k] != 0)
          m_p[k] <= 6'((int'(m_c[k]) + 1) % SN[k]);
      end
    end
  end

  always @(negedge clk) begin : mon_sw
    logic [63:0] mg;
    if (s_chk) begin
      for (int k = 0; k < 6; k++) begin
        mg = m_v[k] ? (64'd1 << m_c[k]) : 64'd0;
        chk($sformatf("sweep%0d", k),
            80'({sv[k], sg[k], sc[k]}),
            80'({m_v[k], mg, m_c[k]}));
        chk($sformatf("inv%0d", k),
            80'({$onehot0(sg[k]),
                 sg[k] === (sv[k] ? (64'd1 << sc[k]) : 64'd0),
                 int'(sc[k]) < SN[k]}),
            80'(3'b111));
      end
    end
  end

  initial begin : sweep
    s_rst = 1'b1; s_req = '0; s_done = 1'b0;
    s_chk = 1'b0; sw_done = 1'b0;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      #1;
      s_chk = 1'b1;
      s_req = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0)
        s_req = s_req & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) s_req = '0;
      s_done = ($urandom_range(0, 2) == 0);
      s_rst  = ($urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    #1;
    s_chk = 1'b0;
    sw_done = 1'b1;
  end

  initial begin : main
    fx_rst = 1'b1; fx_req = '0; fx_done = 1'b0;
    rr_rst = 1'b1; rr_req = '0; rr_done = 1'b0;

    cf(1, 8'hFF, 0, 0, 8'h00, 0);
    cf(1, 8'hFF, 0, 0, 8'h00, 0);
    cf(0, 8'hFF, 0, 1, 8'h01, 0);
    cf(0, 8'hFF, 1, 0, 8'h00, 0);
    cf(0, 8'hA4, 0, 1, 8'h04, 2);
    repeat (5) cf(0, 8'h01, 0, 1, 8'h04, 2);
    cf(0, 8'h01, 1, 0, 8'h00, 0);
    cf(0, 8'h01, 0, 1, 8'h01, 0);
    cf(0, 8'h00, 1, 0, 8'h00, 0);
    cf(0, 8'h00, 1, 0, 8'h00, 0);
    cf(0, 8'h00, 0, 0, 8'h00, 0);
    cf(0, 8'h80, 0, 1, 8'h80, 7);
    cf(1, 8'h80, 1, 0, 8'h00, 0);
    cf(0, 8'h60, 0, 1, 8'h20, 5);
    cf(0, 8'h00, 1, 0, 8'h00, 0);

    cr(1, 8'hFF, 0, 0, 8'h00, 0);
    cr(1, 8'hFF, 0, 0, 8'h00, 0);
    for (int i = 0; i < 9; i++) begin
      cr(0, 8'hFF, 0, 1, 8'd1 << (i % 8), 3'(i % 8));
      cr(0, 8'hFF, 1, 0, 8'h00, 0);
    end
    cr(0, 8'h04, 0, 1, 8'h04, 2);
    cr(0, 8'h04, 1, 0, 8'h00, 0);
    cr(0, 8'h03, 0, 1, 8'h01, 0);
    cr(0, 8'h03, 1, 0, 8'h00, 0);
    cr(0, 8'h03, 0, 1, 8'h02, 1);
    cr(0, 8'h00, 0, 1, 8'h02, 1);
    cr(0, 8'h00, 1, 0, 8'h00, 0);
    cr(0, 8'hFF, 0, 1, 8'h04, 2);
    cr(1, 8'hFF, 1, 0, 8'h00, 0);
    cr(0, 8'hFF, 0, 1, 8'h01, 0);
    cr(0, 8'hFF, 1, 0, 8'h00, 0);
    cr(0, 8'h81, 0, 1, 8'h80, 7);
    cr(0, 8'h81, 1, 0, 8'h00, 0);
    cr(0, 8'h81, 0, 1, 8'h01, 0);
    cr(0, 8'h00, 1, 0, 8'h00, 0);

    repeat (3) @(negedge clk);
    chk("drain", 80'(q_fx.size() + q_rr.size()), 80'(0));

    for (int b = 0; b < 2000 && !sw_done; b++) @(negedge clk);
    chk("sweep_end", 80'(sw_done), 80'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
